// File: rtl/fb_pkg.sv
// Shared constants, types and helpers for the frame-buffer scan-out path.
package fb_pkg;

    localparam int unsigned FB_W_DEF   = 640;
    localparam int unsigned FB_H_DEF   = 360;
    localparam int unsigned R_BITS_DEF = 3;
    localparam int unsigned G_BITS_DEF = 3;
    localparam int unsigned B_BITS_DEF = 2;

    localparam int unsigned PAL_CH_W = 4;

    typedef struct packed {
        logic [PAL_CH_W-1:0] r;
        logic [PAL_CH_W-1:0] g;
        logic [PAL_CH_W-1:0] b;
    } pal_entry_t;

    // Channel values are passed MSB-aligned in a TRUNC_W field; the result
    // holds the top `bits` bits in its LSBs, so any channel width up to
    // TRUNC_W works.
    localparam int unsigned TRUNC_W = 8;

    function automatic logic [TRUNC_W-1:0] trunc_ch(input logic [TRUNC_W-1:0] value,
                                                    input int unsigned       bits);
        return value >> (TRUNC_W - bits);
    endfunction

endpackage

// File: rtl/fb_palette.sv
// Palette register array: one write port, one registered read port with enable.
module fb_palette #(
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned DATA_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << IDX_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // A same-clock write to the read entry is not visible here (old value wins).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q <= '0;
        end else if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scan-out: incremental VRAM addressing with pixel scaling, double
// buffering, palette lookup and sync delay matched to the 3-strobe colour pipeline.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned FB_W        = FB_W_DEF,
    parameter int unsigned FB_H        = FB_H_DEF,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned ADDR_W      = 19,
    parameter int unsigned IDX_W       = 6,
    parameter int unsigned CH_W        = 4,
    parameter int unsigned R_BITS      = R_BITS_DEF,
    parameter int unsigned G_BITS      = G_BITS_DEF,
    parameter int unsigned B_BITS      = B_BITS_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pix_stb,
    input  logic                i_frame_start,
    input  logic                i_active,
    input  logic                i_hs,
    input  logic                i_vs,
    output logic [ADDR_W-1:0]   o_vram_addr,
    input  logic [IDX_W-1:0]    i_vram_data,
    input  logic                i_swap_req,
    output logic                o_swap_ack,
    output logic                o_bank,
    input  logic                i_pal_we,
    input  logic [IDX_W-1:0]    i_pal_addr,
    input  logic [3*CH_W-1:0]   i_pal_data,
    output logic [R_BITS-1:0]   o_r,
    output logic [G_BITS-1:0]   o_g,
    output logic [B_BITS-1:0]   o_b,
    output logic                o_hs,
    output logic                o_vs,
    output logic                o_active
);

    localparam int unsigned PIX_N = FB_W * FB_H;
    localparam int unsigned SUB_W = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

    localparam logic [SUB_W-1:0]  SUB_MAX      = SUB_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] BANK1_BASE   = ADDR_W'(PIX_N);
    localparam logic [ADDR_W-1:0] LAST_OFF     = ADDR_W'(PIX_N - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_OFF = ADDR_W'((FB_H - 1) * FB_W);
    localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(FB_W);

    // Address generator state.
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [SUB_W-1:0]  col_sub_q, col_sub_d;
    logic [SUB_W-1:0]  row_sub_q, row_sub_d;
    logic              done_q, done_d;
    logic              running_q, running_d;
    logic              act_prev_q, act_prev_d;
    logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;

    // Bank swap state.
    logic bank_q, bank_d;
    logic pending_q, pending_d;
    logic ack_q;

    // Colour pipeline.
    logic              act1_q, hs1_q, vs1_q;
    logic              act2_q, hs2_q, vs2_q;
    logic              act3_q, hs3_q, vs3_q;
    logic [IDX_W-1:0]  idx_q;
    logic [3*CH_W-1:0] pal_rdata;
    logic [R_BITS-1:0] r_q, r_d;
    logic [G_BITS-1:0] g_q, g_d;
    logic [B_BITS-1:0] b_q, b_d;
    logic              hs_q, vs_q, active_q;

    logic              fs;
    logic              live;
    logic              swap_now;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] last_row;
    logic [ADDR_W-1:0] c_addr;
    logic [ADDR_W-1:0] c_row_base;
    logic [ADDR_W-1:0] next_row_base;
    logic [SUB_W-1:0]  c_col;
    logic [SUB_W-1:0]  c_row;
    logic              c_done;
    logic              col_wrap;
    logic              row_wrap;

    always_comb begin
        fs        = i_pix_stb & i_frame_start;
        swap_now  = fs & (pending_q | i_swap_req);
        bank_d    = bank_q ^ swap_now;
        pending_d = ~swap_now & (pending_q | i_swap_req);
        live      = running_q | fs;
        // Uses the post-swap bank so a swapping frame starts in the new bank.
        base      = bank_d ? BANK1_BASE : '0;
        last_addr = base + LAST_OFF;
        last_row  = base + LAST_ROW_OFF;

        if (fs) begin
            c_addr     = base;
            c_row_base = base;
            c_col      = '0;
            c_row      = '0;
            c_done     = 1'b0;
        end else begin
            c_addr     = addr_q;
            c_row_base = row_base_q;
            c_col      = col_sub_q;
            c_row      = row_sub_q;
            c_done     = done_q;
        end

        addr_d        = c_addr;
        row_base_d    = c_row_base;
        col_sub_d     = c_col;
        row_sub_d     = c_row;
        done_d        = c_done;
        running_d     = live;
        act_prev_d    = act_prev_q;
        vram_addr_d   = vram_addr_q;
        col_wrap      = 1'b0;
        row_wrap      = 1'b0;
        next_row_base = c_row_base + ROW_STEP;

        if (i_pix_stb) begin
            act_prev_d = i_active;
            if (live) begin
                if (fs) begin
                    vram_addr_d = base;
                end
                if (i_active) begin
                    vram_addr_d = c_addr;
                    col_wrap    = (c_col == SUB_MAX);
                    col_sub_d   = col_wrap ? '0 : c_col + 1'b1;
                    if (col_wrap && !c_done && (c_addr != last_addr)) begin
                        addr_d = c_addr + 1'b1;
                    end
                end else if (act_prev_q && !fs) begin
                    row_wrap  = (c_row == SUB_MAX);
                    row_sub_d = row_wrap ? '0 : c_row + 1'b1;
                    col_sub_d = '0;
                    // Past the last stored row: park on the final address.
                    if (c_done || (row_wrap && (c_row_base == last_row))) begin
                        done_d = 1'b1;
                        addr_d = last_addr;
                    end else if (row_wrap) begin
                        row_base_d = next_row_base;
                        addr_d     = next_row_base;
                    end else begin
                        addr_d = c_row_base;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q      <= '0;
            row_base_q  <= '0;
            col_sub_q   <= '0;
            row_sub_q   <= '0;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
            act_prev_q  <= 1'b0;
            vram_addr_q <= '0;
            bank_q      <= 1'b0;
            pending_q   <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            row_base_q  <= row_base_d;
            col_sub_q   <= col_sub_d;
            row_sub_q   <= row_sub_d;
            done_q      <= done_d;
            running_q   <= running_d;
            act_prev_q  <= act_prev_d;
            vram_addr_q <= vram_addr_d;
            bank_q      <= bank_d;
            pending_q   <= pending_d;
            ack_q       <= swap_now;
        end
    end

    fb_palette #(
        .IDX_W  (IDX_W),
        .DATA_W (3 * CH_W)
    ) u_palette (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (i_pal_we),
        .i_waddr (i_pal_addr),
        .i_wdata (i_pal_data),
        .i_re    (i_pix_stb),
        .i_raddr (idx_q),
        .o_rdata (pal_rdata)
    );

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (act3_q) begin
            r_d = R_BITS'(trunc_ch(TRUNC_W'(pal_rdata[3*CH_W-1 -: CH_W]) << (TRUNC_W - CH_W),
                                   R_BITS));
            g_d = G_BITS'(trunc_ch(TRUNC_W'(pal_rdata[2*CH_W-1 -: CH_W]) << (TRUNC_W - CH_W),
                                   G_BITS));
            b_d = B_BITS'(trunc_ch(TRUNC_W'(pal_rdata[CH_W-1 -: CH_W]) << (TRUNC_W - CH_W),
                                   B_BITS));
        end
    end

    // Until the first frame start after reset the active flag is forced low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act1_q   <= 1'b0;
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            act2_q   <= 1'b0;
            hs2_q    <= 1'b0;
            vs2_q    <= 1'b0;
            idx_q    <= '0;
            act3_q   <= 1'b0;
            hs3_q    <= 1'b0;
            vs3_q    <= 1'b0;
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            active_q <= 1'b0;
        end else if (i_pix_stb) begin
            act1_q   <= i_active & live;
            hs1_q    <= i_hs;
            vs1_q    <= i_vs;
            act2_q   <= act1_q;
            hs2_q    <= hs1_q;
            vs2_q    <= vs1_q;
            idx_q    <= i_vram_data;
            act3_q   <= act2_q;
            hs3_q    <= hs2_q;
            vs3_q    <= vs2_q;
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hs_q     <= hs3_q;
            vs_q     <= vs3_q;
            active_q <= act3_q;
        end
    end

    assign o_vram_addr = vram_addr_q;
    assign o_swap_ack  = ack_q;
    assign o_bank      = bank_q;
    assign o_r         = r_q;
    assign o_g         = g_q;
    assign o_b         = b_q;
    assign o_hs        = hs_q;
    assign o_vs        = vs_q;
    assign o_active    = active_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: 4x2 frame buffer, 2x scaling, 16-entry VRAM model.
module tb_fb_scanout;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned CH_W   = 4;
    localparam int unsigned NVEC   = 50;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              pix_stb = 1'b0;
    logic              frame_start = 1'b0;
    logic              active = 1'b0;
    logic              hsync = 1'b0;
    logic              vsync = 1'b0;
    logic [ADDR_W-1:0] vram_addr;
    logic [IDX_W-1:0]  vram_q = '0;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              bank;
    logic              pal_we = 1'b0;
    logic [IDX_W-1:0]  pal_addr = '0;
    logic [3*CH_W-1:0] pal_data = '0;
    logic [2:0]        o_r;
    logic [2:0]        o_g;
    logic [1:0]        o_b;
    logic              o_hs;
    logic              o_vs;
    logic              o_active;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fb_scanout #(
        .FB_W        (4),
        .FB_H        (2),
        .SCALE_SHIFT (1),
        .ADDR_W      (ADDR_W),
        .IDX_W       (IDX_W),
        .CH_W        (CH_W),
        .R_BITS      (3),
        .G_BITS      (3),
        .B_BITS      (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_pix_stb     (pix_stb),
        .i_frame_start (frame_start),
        .i_active      (active),
        .i_hs          (hsync),
        .i_vs          (vsync),
        .o_vram_addr   (vram_addr),
        .i_vram_data   (vram_q),
        .i_swap_req    (swap_req),
        .o_swap_ack    (swap_ack),
        .o_bank        (bank),
        .i_pal_we      (pal_we),
        .i_pal_addr    (pal_addr),
        .i_pal_data    (pal_data),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_hs          (o_hs),
        .o_vs          (o_vs),
        .o_active      (o_active)
    );

    // VRAM contents: index = (address + 5) mod 16, so address 0 holds index 5.
    function automatic logic [IDX_W-1:0] vram_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s = (a + 19'd5) & 19'd15;
        return s[IDX_W-1:0];
    endfunction

    always @(posedge clk) vram_q <= vram_idx(vram_addr);

    logic [11:0] pal_m [16];

    function automatic logic [7:0] exp_rgb(input logic [IDX_W-1:0] idx);
        logic [11:0] p;
        p = pal_m[idx[3:0]];
        return {p[11:9], p[7:5], p[3:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic strobe(input logic fs, input logic act, input logic hs, input logic vs,
                          input logic sw, input logic pw);
        @(negedge clk);
        pix_stb     = 1'b1;
        frame_start = fs;
        active      = act;
        hsync       = hs;
        vsync       = vs;
        swap_req    = sw;
        pal_we      = pw;
        @(negedge clk);
        pix_stb     = 1'b0;
        frame_start = 1'b0;
        swap_req    = 1'b0;
        pal_we      = 1'b0;
    endtask

    task automatic pal_write(input logic [IDX_W-1:0] a, input logic [11:0] d);
        @(negedge clk);
        pal_we   = 1'b1;
        pal_addr = a;
        pal_data = d;
        @(negedge clk);
        pal_we   = 1'b0;
        pal_m[a[3:0]] = d;
    endtask

    task automatic pulse_swap();
        @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    typedef struct {
        logic              fs;
        logic              act;
        logic              hs;
        logic              vs;
        logic [ADDR_W-1:0] addr;
    } vec_t;

    vec_t       vecs [NVEC];
    logic       h_act [3];
    logic       h_hs  [3];
    logic       h_vs  [3];
    logic [7:0] h_rgb [3];

    initial begin
        // Five lines of 8 active pixels plus 2 blanking strobes; line 4 is an
        // extra line beyond the 2x-scaled 2-row buffer and must stay on address 7.
        for (int l = 0; l < 5; l++) begin
            for (int p = 0; p < 10; p++) begin
                vecs[l*10+p].fs   = (l == 0) && (p == 0);
                vecs[l*10+p].act  = (p < 8);
                vecs[l*10+p].hs   = (p == 8);
                vecs[l*10+p].vs   = (l == 4);
                vecs[l*10+p].addr = (l < 4) ? ADDR_W'((l / 2) * 4 + p / 2) : ADDR_W'(7);
            end
        end
        for (int i = 0; i < 3; i++) begin
            h_act[i] = 1'b0;
            h_hs[i]  = 1'b0;
            h_vs[i]  = 1'b0;
            h_rgb[i] = 8'h00;
        end

        repeat (3) @(negedge clk);
        check("reset_addr", 32'(vram_addr), 32'h0);
        check("reset_bank", 32'(bank), 32'h0);
        check("reset_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        check("reset_sync", 32'({o_hs, o_vs, o_active, swap_ack}), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            pal_write(IDX_W'(i), (i == 5) ? 12'hF0A : {4'(i), 4'(15 - i), 4'(i * 3)});
        end

        // No frame start yet: address parked at 0, colour blank.
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("preframe_addr", 32'(vram_addr), 32'h0);
            check("preframe_active", 32'(o_active), 32'h0);
            check("preframe_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        end

        for (int k = 0; k < NVEC; k++) begin
            strobe(vecs[k].fs, vecs[k].act, vecs[k].hs, vecs[k].vs, 1'b0, 1'b0);
            if (vecs[k].act) check($sformatf("addr[%0d]", k), 32'(vram_addr), 32'(vecs[k].addr));
            check($sformatf("active[%0d]", k), 32'(o_active), 32'(h_act[2]));
            check($sformatf("hs[%0d]", k), 32'(o_hs), 32'(h_hs[2]));
            check($sformatf("vs[%0d]", k), 32'(o_vs), 32'(h_vs[2]));
            check($sformatf("rgb[%0d]", k), 32'({o_r, o_g, o_b}), 32'(h_rgb[2]));
            for (int j = 2; j > 0; j--) begin
                h_act[j] = h_act[j-1];
                h_hs[j]  = h_hs[j-1];
                h_vs[j]  = h_vs[j-1];
                h_rgb[j] = h_rgb[j-1];
            end
            h_act[0] = vecs[k].act;
            h_hs[0]  = vecs[k].hs;
            h_vs[0]  = vecs[k].vs;
            h_rgb[0] = vecs[k].act ? exp_rgb(vram_idx(vecs[k].addr)) : 8'h00;
        end

        // Two requests mid-frame collapse into one swap at the next frame start.
        pulse_swap();
        pulse_swap();
        check("swap_pending_bank", 32'(bank), 32'h0);
        check("swap_pending_ack", 32'(swap_ack), 32'h0);
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("swap_ack", 32'(swap_ack), 32'h1);
        check("swap_bank", 32'(bank), 32'h1);
        check("swap_first_addr", 32'(vram_addr), 32'h8);
        @(negedge clk);
        check("swap_ack_one_clk", 32'(swap_ack), 32'h0);
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bank1_addr1", 32'(vram_addr), 32'h8);
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("bank1_addr2", 32'(vram_addr), 32'h9);
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("single_swap_bank", 32'(bank), 32'h1);
        check("single_swap_ack", 32'(swap_ack), 32'h0);
        check("single_swap_addr", 32'(vram_addr), 32'h8);

        // Blank strobes with hsync high, then a frame start with a coincident
        // swap request; pixel 0 reads index 5 (palette F0A).
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("coinc_ack", 32'(swap_ack), 32'h1);
        check("coinc_bank", 32'(bank), 32'h0);
        check("coinc_addr", 32'(vram_addr), 32'h0);
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pal_addr = 6'd5;
        pal_data = 12'h00F;
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("align_n2_active", 32'(o_active), 32'h0);
        check("align_n2_hs", 32'(o_hs), 32'h1);
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("align_n3_active", 32'(o_active), 32'h1);
        check("align_n3_hs", 32'(o_hs), 32'h0);
        check("align_n3_r", 32'(o_r), 32'h7);
        check("align_n3_g", 32'(o_g), 32'h0);
        check("align_n3_b", 32'(o_b), 32'h2);
        strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("palwr_new_rgb", 32'({o_r, o_g, o_b}), 32'h03);
        strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("coinc_cleared_bank", 32'(bank), 32'h0);
        check("coinc_cleared_ack", 32'(swap_ack), 32'h0);

        // Reset in the middle of a displayed line on bank 1.
        pulse_swap();
        strobe(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("pre_rst_active", 32'(o_active), 32'h1);
        check("pre_rst_bank", 32'(bank), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_addr", 32'(vram_addr), 32'h0);
        check("rst_bank", 32'(bank), 32'h0);
        check("rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        check("rst_sync", 32'({o_hs, o_vs, o_active}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            strobe(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("post_rst_addr", 32'(vram_addr), 32'h0);
            check("post_rst_active", 32'(o_active), 32'h0);
            check("post_rst_rgb", 32'({o_r, o_g, o_b}), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Parametrised frame-buffer scan-out engine between the VGA timing generator and the VGA pins. It generates VRAM read addresses incrementally, with no multiplier, and supports integer power-of-two pixel scaling and double-buffered frames with swaps at frame boundaries. It looks up each index in a run-time writable palette and truncates the colour to the board DAC widths. It delays hsync/vsync by the pipeline depth so sync and colour leave the block aligned.

## Interface
- `FB_W`, 640: frame-buffer width in stored pixels.
- `FB_H`, 360: frame-buffer height in stored pixels.
- `SCALE_SHIFT`, 0: each stored pixel covers 2^SCALE_SHIFT screen pixels horizontally and 2^SCALE_SHIFT lines vertically.
- `ADDR_W`, 19: VRAM address width. Must hold 2·FB_W·FB_H.
- `IDX_W`, 6: palette index width. The palette has 2^IDX_W entries.
- `CH_W`, 4: palette channel width. A palette entry is {R,G,B}, 3·CH_W bits.
- `R_BITS`/`G_BITS`/`B_BITS`, 3/3/2: output DAC widths, each ≤ CH_W.
- `i_clk`, in, 1: system clock.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_pix_stb`, in, 1: pixel strobe. The pipeline advances only when it is high.
- `i_frame_start`, in, 1: first pixel of a frame, qualified by `i_pix_stb`.
- `i_active`, `i_hs`, `i_vs`, in, 1 each: timing-generator outputs.
- `o_vram_addr`, out, ADDR_W: VRAM read address. Synchronous RAM, 1 `i_clk` read latency.
- `i_vram_data`, in, IDX_W: VRAM read data.
- `i_swap_req`, in, 1: one-clock pulse requesting a display-bank swap.
- `o_swap_ack`, out, 1: one-clock pulse when the swap takes effect.
- `o_bank`, out, 1: bank currently being displayed.
- `i_pal_we`, in, 1: palette write enable.
- `i_pal_addr`, in, IDX_W: palette write address.
- `i_pal_data`, in, 3·CH_W: palette write data.
- `o_r`/`o_g`/`o_b`, out, R_BITS/G_BITS/B_BITS: colour outputs.
- `o_hs`/`o_vs`/`o_active`, out, 1 each: aligned sync and active outputs.

## Operation
- **Bank bases.** Bank 0 base is 0. Bank 1 base is FB_W·FB_H, a constant.
- **Frame start.** On a strobe with `i_frame_start`:
  - row_base, addr ← base of bank.
  - col_sub, row_sub ← 0.
  - A pending swap is applied first, so the new frame reads the new bank.
- **Active strobes.** col_sub increments. When it wraps from 2^SCALE_SHIFT−1, addr increments.
- **End of line** (`i_active` falling, sampled on strobe). row_sub increments.
  - row_sub wraps → row_base += FB_W.
  - In both cases addr ← the updated row_base and col_sub ← 0.
- **Address range.** addr never leaves [base, base+FB_W·FB_H−1]. If the timing generator supplies extra lines, addr holds at the last address.
- **Swap.** `i_swap_req` sets a pending flag.
  - At the next frame start: `o_bank` toggles, the flag clears, and `o_swap_ack` pulses for one `i_clk`.
  - Further requests while pending are absorbed, not queued.
  - A request arriving in the same clock as the frame start is applied at that frame start.
- **Palette.** 2^IDX_W × 3·CH_W register array.
  - Writes occur on any `i_clk` when `i_pal_we`, independent of the strobe.
  - A read and a write to the same entry in one clock: the read returns the old value.
- **Colour.** Each channel takes the MSBs of its palette field, e.g. `o_r` = pal[3·CH_W−1 -: R_BITS]. No rounding.
- **Blanking.** When the delayed active flag is 0, `o_r`/`o_g`/`o_b` = 0.
- **Reset.** All outputs 0, `o_bank`=0, pending=0, addr=0. Palette contents are not reset.
  - Reset mid-frame: scan-out resumes only at the next `i_frame_start`. Until then addr holds 0 and colour outputs 0.

## Timing
- Latency is 3 strobes from `i_active`/`i_hs`/`i_vs` to `o_active`/`o_hs`/`o_vs` and colour:
  - Strobe n: address registered.
  - Strobe n+1: index captured. Requires strobe spacing ≥ 2 `i_clk`.
  - Strobe n+2: palette entry registered.
  - Strobe n+3: truncated colour and delayed syncs registered.
- Syncs pass through the same 3-strobe shift register, so they are exactly aligned with colour.
- With `i_pix_stb` tied high, behaviour is undefined (RAM latency is violated). Minimum strobe period is 2 clocks.

## Structure
- Shared package `fb_pkg`:
  - `FB_W`/`FB_H` defaults.
  - DAC widths R/G/B_BITS.
  - Palette entry typedef {r,g,b}.
  - Function `trunc_ch(value, bits)`.
- Sub-module `fb_palette`: palette register array with write port and registered read port. It is reused later by the sprite layer.

## Test plan
- **Reset and blanking.** Assert `i_rst` mid-line → all outputs 0 on the same clock. After release with no frame start → `o_vram_addr`=0 and colour stays 0.
- **Addressing, SCALE_SHIFT=1, FB_W=4, FB_H=2.** One frame → addresses 0,0,1,1,2,2,3,3 on line 0, the same on line 1, then 4,4,…,7,7 on lines 2–3. Extra lines hold at 7.
- **Alignment.** Active pixel with index 5, palette[5]=12'hF0A → exactly 3 strobes later `o_active`=1 and `o_r`=3'b111, `o_g`=3'b000, `o_b`=2'b10. `o_hs` edge is shifted by the same 3 strobes.
- **Swap.** `i_swap_req` mid-frame → `o_bank` unchanged until the next `i_frame_start`. Then `o_bank`=1, a one-clock `o_swap_ack`, and the first address equals FB_W·FB_H. Two requests in one frame → one swap.
- **Palette write during scan-out.** Write palette[5]=12'h00F while index 5 is being read → the same-clock read gives the old colour and the next read gives `o_b`=2'b11.
- **Coincident events.** `i_swap_req` in the same clock as `i_frame_start` → the swap applies at that frame.
